imsic_msi_rcv: RTL and testbench

- CSR-domain receiver for the MSI info bus produced by the IMSIC register-map/FIFO stage.
- That stage holds msi_info stable and keeps msi_info_vld high for SETIP_KEEP_CYCLES cycles of its own clock.
- This block synchronizes the valid level, detects each new message, and captures and decodes the info word.
- Accepted messages become a one-cycle setipnum write strobe, targeted at one interrupt file of this hart; malformed or foreign messages are dropped and counted.

---
 rtl/imsic_msi_rcv.sv | 140 ++++++++++++++
 tb/tb_imsic_msi_rcv.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imsic_msi_rcv.sv
// imsic_msi_rcv: CSR-domain receiver for the IMSIC MSI info bus.
// The asynchronous stretched valid is synchronized and edge-detected.
// Each new message has its info word captured, decoded and checked
// against this hart. An accepted message becomes a one-cycle setipnum
// write strobe with a one-hot file select. A rejected message becomes a
// one-cycle drop pulse and bumps a saturating error counter.
// Optional build macro IMSIC_MSI_RCV_SYNC3_EN adds a third synchronizer
// flop, which makes every latency one cycle longer.
module imsic_msi_rcv #(
    parameter int NR_SRC_WIDTH    = 8,
    parameter int INTP_FILE_WIDTH = 3,
    parameter int NR_HARTS_WIDTH  = 6,
    parameter int NR_INTP_FILES   = 7,
    parameter int MSI_INFO_WIDTH  = NR_SRC_WIDTH + INTP_FILE_WIDTH + NR_HARTS_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NR_HARTS_WIDTH-1:0] i_hart_id,
    input  logic [MSI_INFO_WIDTH-1:0] i_msi_info,
    input  logic                      i_msi_info_vld,
    output logic [NR_SRC_WIDTH-1:0]   o_setipnum,
    output logic                      o_setipnum_we,
    output logic [NR_INTP_FILES-1:0]  o_setipnum_h,
    output logic                      o_drop,
    output logic [7:0]                o_err_cnt,
    output logic                      o_busy
);

`ifdef IMSIC_MSI_RCV_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    // One bit wider than the file field, so the bound still fits when
    // the file count is a power of two.
    localparam logic [INTP_FILE_WIDTH:0] FILE_LIMIT = (INTP_FILE_WIDTH + 1)'(NR_INTP_FILES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        WAIT = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      vld_s_d_q;
    logic                      vld_s;
    logic                      rise;

    state_e                    state_q;
    logic [MSI_INFO_WIDTH-1:0] info_q;
    logic [NR_SRC_WIDTH-1:0]   setipnum_q;
    logic                      setipnum_we_q;
    logic [NR_INTP_FILES-1:0]  setipnum_h_q;
    logic                      drop_q;
    logic [7:0]                err_cnt_q;
    logic [7:0]                err_cnt_d;

    logic [NR_SRC_WIDTH-1:0]    info_id;
    logic [INTP_FILE_WIDTH-1:0] info_file;
    logic [NR_HARTS_WIDTH-1:0]  info_hart;
    logic [NR_INTP_FILES-1:0]   file_onehot;
    logic                       accept;

    // Valid-level synchronizer chain plus one delayed copy for edge detection.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '0;
            vld_s_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_msi_info_vld};
            vld_s_d_q <= vld_s;
        end
    end

    assign vld_s = sync_q[SYNC_STAGES-1];
    assign rise  = vld_s & ~vld_s_d_q;

    // Decode the captured word. i_msi_info itself is never used outside the capture edge.
    assign info_id     = info_q[NR_SRC_WIDTH-1:0];
    assign info_file   = info_q[NR_SRC_WIDTH+INTP_FILE_WIDTH-1:NR_SRC_WIDTH];
    assign info_hart   = info_q[MSI_INFO_WIDTH-1:MSI_INFO_WIDTH-NR_HARTS_WIDTH];
    assign file_onehot = {{(NR_INTP_FILES-1){1'b0}}, 1'b1} << info_file;
    assign accept      = (info_hart == i_hart_id)
                       && ({1'b0, info_file} < FILE_LIMIT)
                       && (info_id != '0);
    assign err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Message FSM with registered strobes. The strobes default low every cycle,
    // so each one lasts exactly one cycle.
    // NOTE: the captured info word is reset along with the control state, so nothing holds X after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            info_q        <= '0;
            setipnum_q    <= '0;
            setipnum_we_q <= 1'b0;
            setipnum_h_q  <= '0;
            drop_q        <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            setipnum_we_q <= 1'b0;
            drop_q        <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        info_q  <= i_msi_info;
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    state_q <= WAIT;
                    if (accept) begin
                        setipnum_q    <= info_id;
                        setipnum_h_q  <= file_onehot;
                        setipnum_we_q <= 1'b1;
                    end else begin
                        drop_q    <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                    end
                end
                WAIT: begin
                    if (!vld_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_setipnum    = setipnum_q;
    assign o_setipnum_we = setipnum_we_q;
    assign o_setipnum_h  = setipnum_h_q;
    assign o_drop        = drop_q;
    assign o_err_cnt     = err_cnt_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_imsic_msi_rcv.sv
// tb_imsic_msi_rcv: self-checking bench for imsic_msi_rcv.
// The reference model treats the synchronizer as a pure delay of the
// sampled valid. It tracks each message as a capture time, a strobe time
// and a release time. Outputs are compared on every falling clock edge.
// Literal checks pin latency, decode and the counter limits.
module tb_imsic_msi_rcv;

`ifdef IMSIC_MSI_RCV_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [5:0]  hart_id;
    logic [16:0] info;
    logic        vld;
    logic [7:0]  setipnum;
    logic        we;
    logic [6:0]  h;
    logic        drop;
    logic [7:0]  err_cnt;
    logic        busy;

    imsic_msi_rcv dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_hart_id      (hart_id),
        .i_msi_info     (info),
        .i_msi_info_vld (vld),
        .o_setipnum     (setipnum),
        .o_setipnum_we  (we),
        .o_setipnum_h   (h),
        .o_drop         (drop),
        .o_err_cnt      (err_cnt),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int n_we     = 0;
    int n_drop   = 0;
    logic [7:0] ids[$];

    // Reference model state.
    bit          vh[$];           // raw valid sampled at the last SYNC+2 edges, newest last
    int          edge_n;
    bit          m_busy;
    int          strobe_edge;
    logic [16:0] m_info;
    logic [7:0]  exp_num;
    logic        exp_we;
    logic [6:0]  exp_h;
    logic        exp_drop;
    int          exp_cnt;
    logic        exp_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        vh.delete();
        for (int i = 0; i < SYNC + 2; i++) vh.push_back(1'b0);
        edge_n      = 0;
        m_busy      = 1'b0;
        strobe_edge = -1;
        m_info      = '0;
        exp_num     = '0;
        exp_we      = 1'b0;
        exp_h       = '0;
        exp_drop    = 1'b0;
        exp_cnt     = 0;
        exp_busy    = 1'b0;
    endtask

    task automatic deliver();
        logic [5:0] hrt;
        logic [2:0] fl;
        logic [7:0] id;
        hrt = m_info[16:11];
        fl  = m_info[10:8];
        id  = m_info[7:0];
        if (hrt == hart_id && fl < 3'd7 && id != 8'd0) begin
            exp_we  = 1'b1;
            exp_num = id;
            exp_h   = 7'(1 << fl);
        end else begin
            exp_drop = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
        end
    endtask

    // vld_s after edge k equals the raw valid sampled SYNC-1 edges earlier.
    task automatic model_edge();
        bit s_prev;
        bit s_prev2;
        edge_n++;
        vh.push_back(vld);
        void'(vh.pop_front());
        s_prev  = vh[1];
        s_prev2 = vh[0];
        exp_we   = 1'b0;
        exp_drop = 1'b0;
        if (m_busy) begin
            if (edge_n == strobe_edge) deliver();
            else if (!s_prev) m_busy = 1'b0;
        end else if (s_prev && !s_prev2) begin
            m_busy      = 1'b1;
            m_info      = info;
            strobe_edge = edge_n + 1;
        end
        exp_busy = m_busy;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_edge();
        end
    end

    // Advance n cycles, comparing every output against the model on each falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rstn) begin
                check("cyc_setipnum", 32'(setipnum), 32'(exp_num));
                check("cyc_we", 32'(we), 32'(exp_we));
                check("cyc_h", 32'(h), 32'(exp_h));
                check("cyc_drop", 32'(drop), 32'(exp_drop));
                check("cyc_err_cnt", 32'(err_cnt), exp_cnt);
                check("cyc_busy", 32'(busy), 32'(exp_busy));
                if (we) begin
                    n_we++;
                    ids.push_back(setipnum);
                end
                if (drop) n_drop++;
            end
        end
        #1;
    endtask

    task automatic send(input logic [5:0] hrt, input logic [2:0] fl, input logic [7:0] id,
                        input int hi, input int gap);
        info = {hrt, fl, id};
        vld  = 1'b1;
        step(hi);
        vld  = 1'b0;
        step(gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_setipnum"}, 32'(setipnum), 0);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_h"}, 32'(h), 0);
        check({tag, "_drop"}, 32'(drop), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin : stim
        int base_we;
        int base_drop;
        logic [5:0] r_hart;
        logic [7:0] r_id;

        hart_id = 6'd5;
        info    = '0;
        vld     = 1'b0;
        rstn    = 1'b0;
        step(3);
        check_all_zero("rst");
        rstn = 1'b1;
        step(2);

        // Accept: strobe appears SYNC+1 edges after the sampling edge.
        base_we = n_we;
        info = {6'd5, 3'd2, 8'h2A};
        vld  = 1'b1;
        step(SYNC + 1);
        check("lat_before", 32'(we), 0);
        check("busy_capt", 32'(busy), 1);
        step(1);
        check("lat_strobe", 32'(we), 1);
        check("acc_num", 32'(setipnum), 32'h2A);
        check("acc_h", 32'(h), 32'b0000100);
        check("model_num", 32'(exp_num), 32'h2A);
        step(1);
        check("strobe_width", 32'(we), 0);
        check("hold_num", 32'(setipnum), 32'h2A);
        step(8 - (SYNC + 3));
        vld = 1'b0;
        step(6);
        check("acc_count", n_we - base_we, 1);

        // Foreign hart.
        base_we   = n_we;
        base_drop = n_drop;
        send(6'd6, 3'd0, 8'd3, 4, 6);
        check("foreign_drop", n_drop - base_drop, 1);
        check("foreign_we", n_we - base_we, 0);
        check("foreign_cnt", 32'(err_cnt), 1);

        // Out-of-range file, then zero id; the counter is cumulative with the foreign drop.
        send(6'd5, 3'd7, 8'h21, 4, 6);
        send(6'd5, 3'd1, 8'h00, 4, 6);
        check("bad_drop", n_drop - base_drop, 3);
        check("bad_we", n_we - base_we, 0);
        check("bad_cnt", 32'(err_cnt), 3);
        check("model_cnt", exp_cnt, 3);
        check("bad_h_kept", 32'(h), 32'b0000100);

        // Long valid: busy drops SYNC+1 edges after the valid falls.
        base_we = n_we;
        info = {6'd5, 3'd3, 8'h33};
        vld  = 1'b1;
        step(40);
        vld = 1'b0;
        step(SYNC);
        check("long_busy_hold", 32'(busy), 1);
        step(1);
        check("long_busy_clr", 32'(busy), 0);
        check("long_count", n_we - base_we, 1);
        check("long_num", 32'(setipnum), 32'h33);
        check("long_h", 32'(h), 32'b0001000);
        step(3);

        // Single-cycle valid.
        base_we = n_we;
        info = {6'd5, 3'd4, 8'h44};
        vld  = 1'b1;
        step(1);
        vld = 1'b0;
        step(8);
        check("short_count", n_we - base_we, 1);
        check("short_num", 32'(setipnum), 32'h44);
        check("short_h", 32'(h), 32'b0010000);

        // Back-to-back with a 2-cycle low gap.
        ids.delete();
        send(6'd5, 3'd1, 8'h10, 3, 2);
        send(6'd5, 3'd1, 8'h11, 3, 6);
        check("b2b_count", ids.size(), 2);
        check("b2b_first", 32'(ids[0]), 32'h10);
        check("b2b_second", 32'(ids[1]), 32'h11);

        // Randomized traffic checked cycle by cycle against the model.
        for (int m = 0; m < 80; m++) begin
            r_hart = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd5;
            r_id   = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
            send(r_hart, 3'($urandom), r_id, int'($urandom_range(12, 1)), int'($urandom_range(6, 2)));
        end

        // Saturation.
        repeat (300) send(6'd6, 3'd0, 8'd3, 2, 3);
        check("sat_cnt", 32'(err_cnt), 255);
        check("model_sat", exp_cnt, 255);

        // Reset while in CAPT.
        info = {6'd5, 3'd5, 8'h55};
        vld  = 1'b1;
        step(SYNC + 1);
        check("rst_capt_busy", 32'(busy), 1);
        check("rst_capt_we", 32'(we), 0);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        vld = 1'b0;
        step(3);
        rstn = 1'b1;
        base_we = n_we;
        step(10);
        check("rst_no_strobe", n_we - base_we, 0);
        check("rst_idle", 32'(busy), 0);
        check("rst_cnt", 32'(err_cnt), 0);

        // Valid already high when reset releases is delivered once.
        rstn = 1'b0;
        info = {6'd5, 3'd6, 8'h66};
        vld  = 1'b1;
        step(2);
        rstn = 1'b1;
        base_we = n_we;
        step(10);
        vld = 1'b0;
        step(6);
        check("rel_count", n_we - base_we, 1);
        check("rel_num", 32'(setipnum), 32'h66);
        check("rel_h", 32'(h), 32'b1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
